sha2_round_unit: RTL



---
 rtl/sha2_round_unit_if.sv | 78 +++++++
 rtl/sha2_round_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sha2_round_unit_if.sv
// ---------------------------------------------------------------------------
// sha2_round_unit_if
//
// Bundle of every datapath-facing signal of the SHA-2 round unit, so the unit
// can be dropped into a Versat slot with a single port.
//
// Parameters
//   WORD_W   word width (32 = SHA-224/256, 64 = SHA-384/512)
//   DELAY_W  width of the start-delay configuration
//   ROUND_W  width of the round-count configuration
//
// Signals (direction seen from the round unit, i.e. the slave modport)
//   running    in   accelerator running; low freezes all state
//   run        in   one-cycle start pulse, loads configuration
//   done       out  high while idle or holding a finished digest
//   busy       out  high while waiting, hashing or feeding forward
//   in0..in7   in   initial hash words H0..H7 (a..h)
//   in8        in   message word W_t
//   in9        in   round constant K_t
//   out0..out7 out  registered working state a..h
//   delay0     in   cycles to wait after run before the load cycle
//   rounds0    in   number of rounds to perform
//   feed_fwd0  in   add the saved initial hash after the last round
// ---------------------------------------------------------------------------
interface sha2_round_unit_if #(
    parameter int WORD_W  = 32,
    parameter int DELAY_W = 7,
    parameter int ROUND_W = 7
);

    logic               running;
    logic               run;
    logic               done;
    logic               busy;

    logic [WORD_W-1:0]  in0;
    logic [WORD_W-1:0]  in1;
    logic [WORD_W-1:0]  in2;
    logic [WORD_W-1:0]  in3;
    logic [WORD_W-1:0]  in4;
    logic [WORD_W-1:0]  in5;
    logic [WORD_W-1:0]  in6;
    logic [WORD_W-1:0]  in7;
    logic [WORD_W-1:0]  in8;
    logic [WORD_W-1:0]  in9;

    logic [WORD_W-1:0]  out0;
    logic [WORD_W-1:0]  out1;
    logic [WORD_W-1:0]  out2;
    logic [WORD_W-1:0]  out3;
    logic [WORD_W-1:0]  out4;
    logic [WORD_W-1:0]  out5;
    logic [WORD_W-1:0]  out6;
    logic [WORD_W-1:0]  out7;

    logic [DELAY_W-1:0] delay0;
    logic [ROUND_W-1:0] rounds0;
    logic               feed_fwd0;

    // Datapath side: supplies operands and configuration, reads the state.
    modport master (
        output running, run,
        output in0, in1, in2, in3, in4, in5, in6, in7, in8, in9,
        output delay0, rounds0, feed_fwd0,
        input  done, busy,
        input  out0, out1, out2, out3, out4, out5, out6, out7
    );

    // Round unit side.
    modport slave (
        input  running, run,
        input  in0, in1, in2, in3, in4, in5, in6, in7, in8, in9,
        input  delay0, rounds0, feed_fwd0,
        output done, busy,
        output out0, out1, out2, out3, out4, out5, out6, out7
    );

endinterface

// File: rtl/sha2_round_unit.sv
// ---------------------------------------------------------------------------
// sha2_round_unit
//
// Parametrised SHA-2 compression-round unit for the Versat datapath.
// One compression round is performed per cycle on the registered working
// state a..h, using the message word W_t and round constant K_t streamed in
// by the datapath each cycle. WORD_W selects the SHA-256 (32) or SHA-512 (64)
// round functions. After the configured number of rounds the saved initial
// hash can optionally be added back (feed-forward) to produce the digest.
//
// Ports
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   sha2_round_unit_if slave modport (operands, config, state, status)
//
// Operation summary
//   run pulse  -> latch delay0/rounds0/feed_fwd0, enter WAIT (any state)
//   WAIT       -> count delay down; on the load cycle save H0..H7 and either
//                 perform round 0 on in0..in7 or copy them through
//   ROUND      -> one round per cycle until the configured count is reached
//   FEED       -> a..h += saved H0..H7
//   HOLD/IDLE  -> state held, done high, only run leaves
// ---------------------------------------------------------------------------
module sha2_round_unit #(
    parameter int WORD_W  = 32,
    parameter int DELAY_W = 7,
    parameter int ROUND_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    sha2_round_unit_if.slave  bus
);

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
            $error("sha2_round_unit: WORD_W must be 32 or 64");
        end
    endgenerate

    // Big-sigma rotate amounts for the selected SHA-2 family.
    localparam int S0_R0 = (WORD_W == 64) ? 28 : 2;
    localparam int S0_R1 = (WORD_W == 64) ? 34 : 13;
    localparam int S0_R2 = (WORD_W == 64) ? 39 : 22;
    localparam int S1_R0 = (WORD_W == 64) ? 14 : 6;
    localparam int S1_R1 = (WORD_W == 64) ? 18 : 11;
    localparam int S1_R2 = (WORD_W == 64) ? 41 : 25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ROUND,
        S_FEED,
        S_HOLD
    } state_t;

    typedef logic [WORD_W-1:0] word_t;

    state_t             state;
    word_t              st     [8];
    word_t              h_save [8];
    logic [DELAY_W-1:0] delay_cnt;
    logic [ROUND_W-1:0] round_cnt;
    logic [ROUND_W-1:0] rounds_cfg;
    logic               feed_cfg;

    word_t              in_w   [8];
    word_t              src    [8];
    word_t              nxt    [8];
    word_t              big_s0;
    word_t              big_s1;
    word_t              ch;
    word_t              maj;
    word_t              t1;
    word_t              t2;
    logic [ROUND_W-1:0] round_nxt;
    state_t             end_state;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // Round datapath. On the load cycle the round operates directly on the
    // incoming initial hash so that round 0 does not cost an extra cycle;
    // afterwards it operates on the registered working state.
    always_comb begin
        in_w[0] = bus.in0;
        in_w[1] = bus.in1;
        in_w[2] = bus.in2;
        in_w[3] = bus.in3;
        in_w[4] = bus.in4;
        in_w[5] = bus.in5;
        in_w[6] = bus.in6;
        in_w[7] = bus.in7;

        for (int i = 0; i < 8; i++) begin
            src[i] = (state == S_WAIT) ? in_w[i] : st[i];
        end

        big_s0 = rotr(src[0], S0_R0) ^ rotr(src[0], S0_R1) ^ rotr(src[0], S0_R2);
        big_s1 = rotr(src[4], S1_R0) ^ rotr(src[4], S1_R1) ^ rotr(src[4], S1_R2);
        ch     = (src[4] & src[5]) ^ (~src[4] & src[6]);
        maj    = (src[0] & src[1]) ^ (src[0] & src[2]) ^ (src[1] & src[2]);
        t1     = src[7] + big_s1 + ch + bus.in9 + bus.in8;
        t2     = big_s0 + maj;

        nxt[0] = t1 + t2;
        nxt[1] = src[0];
        nxt[2] = src[1];
        nxt[3] = src[2];
        nxt[4] = src[3] + t1;
        nxt[5] = src[4];
        nxt[6] = src[5];
        nxt[7] = src[6];
    end

    // Bookkeeping shared by the load cycle and the round cycles.
    always_comb begin
        round_nxt = round_cnt + ROUND_W'(1);
        end_state = feed_cfg ? S_FEED : S_HOLD;
    end

    // Control FSM and all state registers. run wins over everything, even
    // while the accelerator is stalled, so the datapath can always restart
    // the unit; otherwise nothing moves while running is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            delay_cnt  <= '0;
            round_cnt  <= '0;
            rounds_cfg <= '0;
            feed_cfg   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                st[i]     <= '0;
                h_save[i] <= '0;
            end
        end else if (bus.run) begin
            state      <= S_WAIT;
            delay_cnt  <= bus.delay0;
            rounds_cfg <= bus.rounds0;
            feed_cfg   <= bus.feed_fwd0;
            round_cnt  <= '0;
        end else if (bus.running) begin
            case (state)
                S_WAIT: begin
                    if (delay_cnt != '0) begin
                        delay_cnt <= delay_cnt - DELAY_W'(1);
                    end else begin
                        for (int i = 0; i < 8; i++) begin
                            h_save[i] <= in_w[i];
                        end
                        if (rounds_cfg != '0) begin
                            for (int i = 0; i < 8; i++) begin
                                st[i] <= nxt[i];
                            end
                            round_cnt <= ROUND_W'(1);
                            state     <= (rounds_cfg == ROUND_W'(1)) ? end_state : S_ROUND;
                        end else begin
                            // Zero rounds: pass the initial hash straight through.
                            for (int i = 0; i < 8; i++) begin
                                st[i] <= in_w[i];
                            end
                            state <= end_state;
                        end
                    end
                end

                S_ROUND: begin
                    for (int i = 0; i < 8; i++) begin
                        st[i] <= nxt[i];
                    end
                    round_cnt <= round_nxt;
                    if (round_nxt == rounds_cfg) begin
                        state <= end_state;
                    end
                end

                S_FEED: begin
                    for (int i = 0; i < 8; i++) begin
                        st[i] <= st[i] + h_save[i];
                    end
                    state <= S_HOLD;
                end

                default: begin
                    // IDLE and HOLD keep everything until the next run.
                end
            endcase
        end
    end

    assign bus.done = (state == S_IDLE) || (state == S_HOLD);
    assign bus.busy = (state == S_WAIT) || (state == S_ROUND) || (state == S_FEED);

    assign bus.out0 = st[0];
    assign bus.out1 = st[1];
    assign bus.out2 = st[2];
    assign bus.out3 = st[3];
    assign bus.out4 = st[4];
    assign bus.out5 = st[5];
    assign bus.out6 = st[6];
    assign bus.out7 = st[7];

endmodule
